// File: rtl/acl2_mode_sequencer.sv
// rtl/acl2_mode_sequencer.sv - PMOD ACL2 driver command sequencer.
// Issues soft-reset/init/start pulses, then supervises streaming with a watchdog and ack timeout.
module acl2_mode_sequencer #(
  parameter int parm_fast_simulation = 0,
  parameter int FCLK                 = 20000000,
  parameter int parm_reset_wait_us   = 1000,
  parameter int parm_watchdog_ms     = 100,
  parameter int parm_ack_timeout     = 255
) (
  input  logic        i_clk_20mhz,
  input  logic        i_rstn_20mhz,
  input  logic        i_enable,
  input  logic        i_sw_mode,
  input  logic        i_command_ready,
  output logic        o_cmd_soft_reset_acl2,
  output logic        o_cmd_init_measur_mode,
  output logic        o_cmd_start_measur_mode,
  output logic        o_cmd_init_linked_mode,
  output logic        o_cmd_start_linked_mode,
  input  logic        i_data_valid,
  output logic        o_running,
  output logic        o_mode_active,
  output logic [15:0] o_sample_count,
  output logic [7:0]  o_fault_count
);

  localparam logic [31:0] RESET_WAIT_CYCLES = (parm_fast_simulation != 0) ? 32'd16
                                            : 32'(FCLK / 1000000 * parm_reset_wait_us);
  localparam logic [31:0] WATCHDOG_CYCLES   = (parm_fast_simulation != 0) ? 32'd64
                                            : 32'(FCLK / 1000 * parm_watchdog_ms);
  localparam logic [7:0]  ACK_LIMIT         = 8'(parm_ack_timeout);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RESET_REQ,
    ST_RESET_ACK,
    ST_RESET_WAIT,
    ST_INIT_REQ,
    ST_INIT_ACK,
    ST_START_REQ,
    ST_START_ACK,
    ST_RUNNING
  } state_t;

  state_t      state, state_n;
  logic [31:0] cnt;
  logic [7:0]  ack_cnt;

  logic pulse_sr, pulse_im, pulse_sm, pulse_il, pulse_sl;
  logic fault_inc, latch_mode, clear_samples;
  logic wd_active, wd_expired, wait_done, ack_expired;

  always_comb begin
    state_n       = state;
    pulse_sr      = 1'b0;
    pulse_im      = 1'b0;
    pulse_sm      = 1'b0;
    pulse_il      = 1'b0;
    pulse_sl      = 1'b0;
    fault_inc     = 1'b0;
    latch_mode    = 1'b0;
    clear_samples = 1'b0;
    // Linked mode is interrupt paced and may legitimately stay silent.
    wd_active     = (state == ST_RUNNING) && !o_mode_active;
    wd_expired    = wd_active && (cnt == WATCHDOG_CYCLES - 32'd1);
    wait_done     = (cnt == RESET_WAIT_CYCLES - 32'd1);
    ack_expired   = (ack_cnt == ACK_LIMIT - 8'd1);

    case (state)
      ST_IDLE: begin
        if (i_enable) state_n = ST_RESET_REQ;
      end
      ST_RESET_REQ: begin
        if (i_command_ready) begin
          pulse_sr = 1'b1;
          state_n  = ST_RESET_ACK;
        end
      end
      ST_RESET_ACK: begin
        if (!i_command_ready) begin
          state_n = ST_RESET_WAIT;
        end else if (ack_expired) begin
          fault_inc = 1'b1;
          state_n   = ST_RESET_REQ;
        end
      end
      ST_RESET_WAIT: begin
        if (wait_done) state_n = ST_INIT_REQ;
      end
      ST_INIT_REQ: begin
        if (i_command_ready) begin
          latch_mode = 1'b1;
          pulse_il   = i_sw_mode;
          pulse_im   = !i_sw_mode;
          state_n    = ST_INIT_ACK;
        end
      end
      ST_INIT_ACK: begin
        if (!i_command_ready) begin
          state_n = ST_START_REQ;
        end else if (ack_expired) begin
          fault_inc = 1'b1;
          state_n   = ST_RESET_REQ;
        end
      end
      ST_START_REQ: begin
        if (i_command_ready) begin
          clear_samples = 1'b1;
          pulse_sl      = o_mode_active;
          pulse_sm      = !o_mode_active;
          state_n       = ST_START_ACK;
        end
      end
      ST_START_ACK: begin
        if (!i_command_ready) begin
          state_n = ST_RUNNING;
        end else if (ack_expired) begin
          fault_inc = 1'b1;
          state_n   = ST_RESET_REQ;
        end
      end
      ST_RUNNING: begin
        if (wd_expired) begin
          fault_inc = 1'b1;
          state_n   = ST_RESET_REQ;
        end else if (i_sw_mode != o_mode_active) begin
          state_n = ST_RESET_REQ;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    // Dropping enable abandons the sequence and suppresses any new pulse or fault.
    if (state != ST_IDLE && !i_enable) begin
      state_n       = ST_IDLE;
      pulse_sr      = 1'b0;
      pulse_im      = 1'b0;
      pulse_sm      = 1'b0;
      pulse_il      = 1'b0;
      pulse_sl      = 1'b0;
      fault_inc     = 1'b0;
      latch_mode    = 1'b0;
      clear_samples = 1'b0;
    end
  end

  always_ff @(posedge i_clk_20mhz) begin
    if (!i_rstn_20mhz) begin
      state                   <= ST_IDLE;
      cnt                     <= 32'd0;
      ack_cnt                 <= 8'd0;
      o_cmd_soft_reset_acl2   <= 1'b0;
      o_cmd_init_measur_mode  <= 1'b0;
      o_cmd_start_measur_mode <= 1'b0;
      o_cmd_init_linked_mode  <= 1'b0;
      o_cmd_start_linked_mode <= 1'b0;
      o_mode_active           <= 1'b0;
      o_sample_count          <= 16'd0;
      o_fault_count           <= 8'd0;
    end else begin
      state                   <= state_n;
      o_cmd_soft_reset_acl2   <= pulse_sr;
      o_cmd_init_measur_mode  <= pulse_im;
      o_cmd_start_measur_mode <= pulse_sm;
      o_cmd_init_linked_mode  <= pulse_il;
      o_cmd_start_linked_mode <= pulse_sl;

      if (latch_mode) o_mode_active <= i_sw_mode;

      if (state_n != state) begin
        ack_cnt <= 8'd0;
      end else if (state == ST_RESET_ACK || state == ST_INIT_ACK || state == ST_START_ACK) begin
        ack_cnt <= ack_cnt + 8'd1;
      end

      // Shared settle / watchdog counter restarts on every state entry and on data.
      if (state_n != state || (state == ST_RUNNING && i_data_valid)) begin
        cnt <= 32'd0;
      end else if (state == ST_RESET_WAIT || wd_active) begin
        cnt <= cnt + 32'd1;
      end

      if (clear_samples) begin
        o_sample_count <= 16'd0;
      end else if (state == ST_RUNNING && i_data_valid && o_sample_count != 16'hFFFF) begin
        o_sample_count <= o_sample_count + 16'd1;
      end

      if (fault_inc && o_fault_count != 8'hFF) o_fault_count <= o_fault_count + 8'd1;
    end
  end

  assign o_running = (state == ST_RUNNING);

endmodule
